// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
//   Each digit gets a slot of PRESCALE clocks. The first GUARD clocks of
//   every slot keep all anodes off so the previous digit cannot ghost.
//   New values enter a one-entry buffer through a valid/ready handshake.
//   They are copied into the display register only at a frame boundary,
//   so a frame never shows a mix of old and new digits.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   en               scan enable; low freezes the scan and blanks the anodes
//   load_valid/data  offered display value (digit0 = [3:0])
//   load_ready       buffer free (no commit pending)
//   lz_blank         leading-zero blanking enable
//   AN_Control       active-low anode enables; [7:4] are unused and held high
//   digit_sel        digit currently scanned
//   nibble           hex value of the scanned digit
//   frame_tick       high during the last cycle of a full frame
module seg_scan_ctrl #(
    parameter int PRESCALE = 8,
    parameter int GUARD    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        lz_blank,
    output logic [7:0]  AN_Control,
    output logic [1:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic        frame_tick
);
    localparam int          CW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dsel_q, dsel_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   buf_q, buf_d;
    logic          pend_q, pend_d;

    logic          boundary;
    logic [3:0]    blank;
    logic          z1, z2, z3;

    assign boundary = en && (dsel_q == 2'd3) && (cnt_q == LAST);

    // zN: display nibbles N..3 are all zero. Digit 0 is never blanked.
    assign z3    = (disp_q[15:12] == 4'h0);
    assign z2    = z3 && (disp_q[11:8] == 4'h0);
    assign z1    = z2 && (disp_q[7:4] == 4'h0);
    assign blank = {z3, z2, z1, 1'b0} & {4{lz_blank}};

    always_comb begin
        cnt_d  = cnt_q;
        dsel_d = dsel_q;
        disp_d = disp_q;
        buf_d  = buf_q;
        pend_d = pend_q;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                dsel_d = dsel_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Commit needs pend_q=1 and capture needs pend_q=0, so at most one
        // of the two branches can fire in a cycle.
        if (boundary && pend_q) begin
            disp_d = buf_q;
            pend_d = 1'b0;
        end else if (load_valid && !pend_q) begin
            buf_d  = load_data;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dsel_q <= 2'd0;
            disp_q <= 16'h0;
            buf_q  <= 16'h0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dsel_q <= dsel_d;
            disp_q <= disp_d;
            buf_q  <= buf_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        AN_Control = 8'hFF;
        if (en && !(cnt_q < GUARD_C) && !blank[dsel_q])
            AN_Control[dsel_q] = 1'b0;
    end

    assign digit_sel  = dsel_q;
    assign nibble     = disp_q[{dsel_q, 2'b00} +: 4];
    assign load_ready = !pend_q;
    assign frame_tick = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl. A behavioural model tracks the scan as one
// position within the frame (0..4*P-1), plus the display value, the buffer
// and the pending flag. Directed scenarios come first, then random traffic.
module tb_seg_scan_ctrl;
    localparam int P = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst, en, load_valid, lz_blank;
    logic [15:0] load_data;
    logic        load_ready, frame_tick;
    logic [7:0]  AN_Control;
    logic [1:0]  digit_sel;
    logic [3:0]  nibble;

    seg_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .lz_blank(lz_blank),
        .AN_Control(AN_Control), .digit_sel(digit_sel), .nibble(nibble),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference state
    int          pos;
    logic [15:0] m_disp, m_buf;
    bit          m_pend;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    // Compare every output with the model for the current inputs.
    task automatic check_model();
        int dig, slot;
        logic [7:0]  e_an;
        logic [15:0] upper;
        dig  = pos / P;
        slot = pos % P;
        upper = m_disp >> (4 * dig);
        e_an = 8'hFF;
        if (en && slot >= G && !(lz_blank && dig > 0 && upper == 16'h0))
            e_an[dig] = 1'b0;
        chk("an",    16'(AN_Control), 16'(e_an));
        chk("dsel",  16'(digit_sel),  16'(dig));
        chk("nib",   16'(nibble),     16'(upper[3:0]));
        chk("ready", 16'(load_ready), 16'(!m_pend));
        chk("tick",  16'(frame_tick), 16'(en && pos == 4*P-1));
    endtask

    task automatic model_update();
        bit tk;
        tk = en && (pos == 4*P-1);
        if (rst) begin
            pos = 0; m_disp = 0; m_buf = 0; m_pend = 0;
        end else begin
            if (tk && m_pend) begin
                m_disp = m_buf; m_pend = 0;
            end else if (load_valid && !m_pend) begin
                m_buf = load_data; m_pend = 1;
            end
            if (en) pos = (pos + 1) % (4*P);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        check_model();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        rst = 1; en = 0; load_valid = 0; load_data = 0; lz_blank = 0;
        pos = 0; m_disp = 0; m_buf = 0; m_pend = 0;
        @(posedge clk); #1;
        step(); step();
        rst = 0; en = 1; cyc = 0;

        // Basic scan, plus a load of 1234 at cycle 3.
        for (int i = 0; i < 64; i++) begin
            load_valid = (cyc == 3);
            load_data  = (cyc == 3) ? 16'h1234 : 16'h0;
            settle();
            if (cyc == 0)  chk("rst_an",  16'(AN_Control), 16'h00FF);
            if (cyc == 0)  chk("rst_nib", 16'(nibble), 16'h0);
            if (cyc == 2)  chk("an_d0",   16'(AN_Control), 16'h00FE);
            if (cyc == 10) chk("an_d1",   16'(AN_Control), 16'h00FD);
            if (cyc == 20) chk("an_d2",   16'(AN_Control), 16'h00FB);
            if (cyc == 30) chk("an_d3",   16'(AN_Control), 16'h00F7);
            if (cyc == 31) chk("tick31",  16'(frame_tick), 16'h1);
            if (cyc == 30) chk("tick30",  16'(frame_tick), 16'h0);
            if (cyc == 4)  chk("busy4",   16'(load_ready), 16'h0);
            if (cyc == 32) chk("nib32",   16'(nibble), 16'h4);
            if (cyc == 32) chk("rdy32",   16'(load_ready), 16'h1);
            if (cyc == 40) chk("nib40",   16'(nibble), 16'h3);
            if (cyc == 56) chk("nib56",   16'(nibble), 16'h1);
            advance();
        end

        // Back-to-back loads: second held while pending, committed a frame later.
        load_valid = 1; load_data = 16'hABCD;
        step();
        load_data = 16'h0050;
        for (int i = 0; i < 80; i++) begin
            if (m_pend == 0 && m_buf == 16'h0050) load_valid = 0;
            step();
        end
        load_valid = 0;

        // Leading-zero blanking with 0050.
        lz_blank = 1;
        for (int i = 0; i < 70; i++) begin
            settle();
            if (m_disp == 16'h0050 && pos == 4*P-2) chk("lz_d3", 16'(AN_Control), 16'h00FF);
            advance();
        end

        // Pause at digit 2, count 5.
        for (int i = 0; i < 64 && pos != 2*P+5; i++) step();
        chk("pause_pos", 16'(pos), 16'(2*P+5));
        en = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("pause_an",   16'(AN_Control), 16'h00FF);
            chk("pause_dsel", 16'(digit_sel),  16'h2);
            chk("pause_tick", 16'(frame_tick), 16'h0);
            advance();
        end
        en = 1;
        for (int i = 0; i < 20; i++) step();

        // Reset with data pending mid-frame.
        load_valid = 1; load_data = 16'h9876;
        step();
        load_valid = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        settle();
        chk("post_rst_rdy", 16'(load_ready), 16'h1);
        chk("post_rst_nib", 16'(nibble),     16'h0);
        chk("post_rst_an",  16'(AN_Control), 16'h00FF);
        advance();
        // Display 0 with blanking: only digit 0 driven.
        for (int i = 0; i < 40; i++) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) lz_blank = 1'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            en         = ($urandom_range(0, 7) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       load_data = 16'h0;
                1:       load_data = 16'($urandom_range(0, 15));
                2:       load_data = 16'($urandom_range(0, 255));
                default: load_data = 16'($urandom);
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
